slg46620_cnt_dly: RTL and testbench

Single 14-bit counter/delay macrocell modelled on the SLG46620 CNT/DLY block. Selectable clock-enable source, delay-line mode and counter mode, with an optional up-count/keep FSM extension and an edge-detect output. It is instantiated per macrocell in the GreenPAK-style fabric model. All logic runs on one system clock; the divided "macrocell clocks" enter as clock-enable strobes.

---
 rtl/slg46620_cnt0_pkg.sv | 25 ++
 rtl/slg46620_cnt_dly_if.sv | 32 +++
 rtl/cnt_dly_edge_detect.sv | 42 ++++
 rtl/slg46620_cnt_dly.sv | 120 ++++++++++++
 tb/tb_slg46620_cnt_dly.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/slg46620_cnt0_pkg.sv
// Shared types and constants for the SLG46620-style CNT/DLY macrocell.
package slg46620_cnt0_pkg;

    typedef enum logic {
        DLY = 1'b0,
        CNT = 1'b1
    } func_t;

    typedef enum logic [1:0] {
        Rising_Edge  = 2'd0,
        Falling_Edge = 2'd1,
        Both_Edge    = 2'd2,
        High_Level   = 2'd3
    } edge_t;

    localparam int              CNT_W   = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = 14'h3FFF;
    localparam logic [CNT_W-1:0] CNT_ONE = 14'd1;

    // Count value at which a tick produces the output pulse.
    function automatic logic [CNT_W-1:0] terminal_count(input logic up);
        return up ? CNT_MAX : '0;
    endfunction

endpackage

// File: rtl/slg46620_cnt_dly_if.sv
// Configuration, data and output signals of one CNT/DLY macrocell.
interface slg46620_cnt_dly_if;
    import slg46620_cnt0_pkg::*;

    logic [3:0]       i_clk_source_mux;
    logic [15:0]      i_clk_ens;
    logic [CNT_W-1:0] i_data_from_register;
    func_t            i_macrocell_function_select;
    edge_t            i_edge_reset_mode_select;
    logic             i_reset_set_mode;
    logic             i_keep;
    logic             i_up;
    logic             i_resetin_timer;
    logic             i_in;
    logic             o_out;
    logic             o_edge_detect_out;

    modport master (
        output i_clk_source_mux, i_clk_ens, i_data_from_register,
               i_macrocell_function_select, i_edge_reset_mode_select,
               i_reset_set_mode, i_keep, i_up, i_resetin_timer, i_in,
        input  o_out, o_edge_detect_out
    );

    modport slave (
        input  i_clk_source_mux, i_clk_ens, i_data_from_register,
               i_macrocell_function_select, i_edge_reset_mode_select,
               i_reset_set_mode, i_keep, i_up, i_resetin_timer, i_in,
        output o_out, o_edge_detect_out
    );

endinterface

// File: rtl/cnt_dly_edge_detect.sv
// Registers the previous input level and flags transitions matching the selected edge mode.
module cnt_dly_edge_detect
    import slg46620_cnt0_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in,
    input  edge_t mode,
    input  logic  suppress,
    output logic  evt,
    output logic  toggle,
    output logic  edge_out
);

    logic prev_q, prev_d;
    logic edge_out_q, edge_out_d;

    always_comb begin
        toggle = in ^ prev_q;
        case (mode)
            Rising_Edge:  evt = in & ~prev_q;
            Falling_Edge: evt = ~in & prev_q;
            Both_Edge:    evt = in ^ prev_q;
            default:      evt = in;
        endcase
        prev_d     = in;
        edge_out_d = evt & ~suppress;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= 1'b0;
            edge_out_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            edge_out_q <= edge_out_d;
        end
    end

    assign edge_out = edge_out_q;

endmodule

// File: rtl/slg46620_cnt_dly.sv
// SLG46620-style 14-bit counter/delay macrocell: periodic pulse (CNT) or edge delay/glitch filter (DLY).
// Define SLG_CNT_DLY_FSM_EN to honour i_up/i_keep; otherwise the counter always counts down.
module slg46620_cnt_dly
    import slg46620_cnt0_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    slg46620_cnt_dly_if.slave bus
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             out_q, out_d;
    logic             init_q, init_d;
    logic             pending_q, pending_d;
    logic             target_q, target_d;

    logic             tick, evt, toggle, up_en, keep_en;
    logic [CNT_W-1:0] n_val, term;
    edge_t            eff_mode;

`ifdef SLG_CNT_DLY_FSM_EN
    assign up_en   = bus.i_up;
    assign keep_en = bus.i_keep;
`else
    logic unused_fsm_inputs;
    assign up_en             = 1'b0;
    assign keep_en           = 1'b0;
    assign unused_fsm_inputs = bus.i_up ^ bus.i_keep;
`endif

    assign tick  = bus.i_clk_ens[bus.i_clk_source_mux];
    assign n_val = bus.i_data_from_register;
    assign term  = terminal_count(up_en);

    // A level has no meaning for a delay line, so DLY treats High_Level as Both_Edge.
    always_comb begin
        eff_mode = bus.i_edge_reset_mode_select;
        if (bus.i_macrocell_function_select == DLY && eff_mode == High_Level)
            eff_mode = Both_Edge;
    end

    cnt_dly_edge_detect u_edge (
        .clk      (i_clk),
        .rst      (i_reset),
        .in       (bus.i_in),
        .mode     (eff_mode),
        .suppress (init_q),
        .evt      (evt),
        .toggle   (toggle),
        .edge_out (bus.o_edge_detect_out)
    );

    always_comb begin
        count_d   = count_q;
        out_d     = out_q;
        init_d    = 1'b0;
        pending_d = pending_q;
        target_d  = target_q;
        if (init_q || bus.i_resetin_timer) begin
            count_d   = n_val;
            out_d     = 1'b0;
            pending_d = 1'b0;
        end else if (bus.i_macrocell_function_select == CNT) begin
            out_d     = 1'b0;
            pending_d = 1'b0;
            if (evt) begin
                count_d = bus.i_reset_set_mode ? term : n_val;
            end else if (tick && !keep_en) begin
                if (count_q == term) begin
                    out_d   = 1'b1;
                    count_d = n_val;
                end else if (up_en) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end else begin
            if (evt) begin
                // An edge back to the current output level is a glitch: drop the pending change.
                if (bus.i_in == out_q) begin
                    pending_d = 1'b0;
                end else begin
                    pending_d = 1'b1;
                    count_d   = n_val;
                    target_d  = bus.i_in;
                end
            end else if (toggle) begin
                out_d     = bus.i_in;
                pending_d = 1'b0;
            end else if (pending_q && tick) begin
                if (count_q == '0) begin
                    out_d     = target_q;
                    pending_d = 1'b0;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q   <= '0;
            out_q     <= 1'b0;
            init_q    <= 1'b1;
            pending_q <= 1'b0;
            target_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            out_q     <= out_d;
            init_q    <= init_d;
            pending_q <= pending_d;
            target_q  <= target_d;
        end
    end

    assign bus.o_out = out_q;

endmodule

// File: tb/tb_slg46620_cnt_dly.sv
// Self-checking bench for slg46620_cnt_dly: per-cycle expected {edge_detect, out} pairs via a scoreboard queue.
module tb_slg46620_cnt_dly;
    import slg46620_cnt0_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    slg46620_cnt_dly_if bus ();

    slg46620_cnt_dly dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tick(input logic t);
        bus.i_clk_ens = ~(16'h1 << bus.i_clk_source_mux);
        bus.i_clk_ens[bus.i_clk_source_mux] = t;
    endtask

    task automatic do_reset(input func_t f, input edge_t m, input logic [13:0] n, input logic sm);
        rst = 1'b1;
        bus.i_macrocell_function_select = f;
        bus.i_edge_reset_mode_select    = m;
        bus.i_data_from_register        = n;
        bus.i_reset_set_mode            = sm;
        bus.i_keep                      = 1'b0;
        bus.i_up                        = 1'b0;
        bus.i_resetin_timer             = 1'b0;
        bus.i_in                        = 1'b0;
        bus.i_clk_source_mux            = 4'($urandom_range(0, 15));
        bus.i_clk_ens                   = '1;
        clk_step();
        clk_step();
        rst = 1'b0;
        clk_step();
    endtask

    task automatic test_reset();
        logic [1:0] got, exp_v;
        rst = 1'b1;
        bus.i_macrocell_function_select = CNT;
        bus.i_edge_reset_mode_select    = High_Level;
        bus.i_data_from_register        = 14'd5;
        bus.i_reset_set_mode            = 1'b0;
        bus.i_keep                      = 1'b0;
        bus.i_up                        = 1'b0;
        bus.i_resetin_timer             = 1'b0;
        bus.i_in                        = 1'b1;
        bus.i_clk_source_mux            = 4'd0;
        bus.i_clk_ens                   = '1;
        exp_q.push_back(2'b00);
        clk_step();
        clk_step();
        got = {bus.o_edge_detect_out, bus.o_out};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_hold got=%b exp=%b", got, exp_v); end
        rst = 1'b0;
        exp_q.push_back(2'b00);
        clk_step();
        got = {bus.o_edge_detect_out, bus.o_out};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL init_quiet got=%b exp=%b", got, exp_v); end
        exp_q.push_back(2'b10);
        clk_step();
        got = {bus.o_edge_detect_out, bus.o_out};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL level_edge got=%b exp=%b", got, exp_v); end
        rst = 1'b1;
        exp_q.push_back(2'b00);
        #1;
        got = {bus.o_edge_detect_out, bus.o_out};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL async_reset_edge got=%b exp=%b", got, exp_v); end
    endtask

    task automatic test_dly_rise();
        logic [1:0] got, exp_v;
        do_reset(DLY, Rising_Edge, 14'd2, 1'b0);
        for (int c = 0; c < 14; c++) begin
            bus.i_in = (c < 10);
            exp_q.push_back({1'(c == 0), 1'(c >= 3 && c < 10)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL dly_rise c=%0d got=%b exp=%b", c, got, exp_v); end
        end
    endtask

    task automatic test_dly_fall();
        logic [1:0] got, exp_v;
        do_reset(DLY, Falling_Edge, 14'd2, 1'b0);
        for (int c = 0; c < 15; c++) begin
            bus.i_in = (c < 4) || (c >= 5 && c < 9) || (c == 14);
            exp_q.push_back({1'(c == 4 || c == 9), 1'(c < 12 || c == 14)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL dly_fall c=%0d got=%b exp=%b", c, got, exp_v); end
        end
    endtask

    task automatic test_cnt_down();
        logic [1:0] got, exp_v;
        do_reset(CNT, Both_Edge, 14'd6, 1'b0);
        for (int c = 0; c < 47; c++) begin
            bus.i_in = (c >= 24 && c < 31);
            exp_q.push_back({1'(c == 24 || c == 31),
                             1'(c == 6 || c == 13 || c == 20 || c == 38 || c == 45)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL cnt_down c=%0d got=%b exp=%b", c, got, exp_v); end
        end
    endtask

    task automatic test_resetin_timer();
        logic [1:0] got, exp_v;
        do_reset(CNT, Rising_Edge, 14'd4, 1'b0);
        for (int c = 0; c < 49; c++) begin
            set_tick(1'(c % 2 == 1));
            bus.i_resetin_timer = (c >= 21 && c <= 27);
            exp_q.push_back({1'b0, 1'(c == 9 || c == 19 || c == 37 || c == 47)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL resetin c=%0d got=%b exp=%b", c, got, exp_v); end
        end
        bus.i_resetin_timer = 1'b0;
    endtask

    task automatic test_set_mode();
        logic [1:0] got, exp_v;
        do_reset(CNT, Rising_Edge, 14'd10, 1'b1);
        for (int c = 0; c < 14; c++) begin
            set_tick(1'(c % 4 == 3));
            bus.i_in = (c >= 8);
            exp_q.push_back({1'(c == 8), 1'(c == 11)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL set_mode c=%0d got=%b exp=%b", c, got, exp_v); end
        end
    endtask

    task automatic test_high_level();
        logic [1:0] got, exp_v;
        do_reset(CNT, High_Level, 14'd3, 1'b0);
        for (int c = 0; c < 14; c++) begin
            bus.i_in = (c < 10);
            exp_q.push_back({1'(c < 10), 1'(c == 13)});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL high_level c=%0d got=%b exp=%b", c, got, exp_v); end
        end
        rst = 1'b1;
        exp_q.push_back(2'b00);
        #1;
        got = {bus.o_edge_detect_out, bus.o_out};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL async_reset_out got=%b exp=%b", got, exp_v); end
    endtask

    task automatic test_fsm();
        logic [1:0] got, exp_v;
        logic       hit;
`ifdef SLG_CNT_DLY_FSM_EN
        do_reset(CNT, Rising_Edge, 14'h3FFB, 1'b0);
`else
        do_reset(CNT, Rising_Edge, 14'd4, 1'b0);
`endif
        bus.i_up = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.i_keep = (c >= 15 && c <= 18);
`ifdef SLG_CNT_DLY_FSM_EN
            hit = (c == 4 || c == 9 || c == 14 || c == 23 || c == 28);
`else
            hit = (c % 5 == 4);
`endif
            exp_q.push_back({1'b0, hit});
            clk_step();
            got = {bus.o_edge_detect_out, bus.o_out};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL fsm c=%0d got=%b exp=%b", c, got, exp_v); end
        end
        bus.i_up   = 1'b0;
        bus.i_keep = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dly_rise();
        test_dly_fall();
        test_cnt_down();
        test_resetin_timer();
        test_set_mode();
        test_high_level();
        test_fsm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
